// File: rtl/rtc_burst_reader.sv
// Burst reader that copies N_REGS consecutive RTC registers over a multiplexed
// address/data bus into a RAM. Optional BCD validation is enabled by RTC_BCD_CHECK_EN.
module rtc_burst_reader #(
  parameter int         N_REGS    = 3,
  parameter int         PHASE_CYC = 8,
  parameter logic [7:0] RTC_BASE  = 8'h24,
  parameter int         RAM_BASE  = 0,
  parameter int         RAM_AW    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              a_d,
  output logic              cs_n,
  output logic              rd_n,
  output logic              wr_n,
  output logic              ad_oe,
  output logic [7:0]        ad_out,
  input  logic [7:0]        ad_in,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    GAP   = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4,
    RECOV = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [5:0]        PH_LAST    = 6'(PHASE_CYC - 1);
  localparam logic [3:0]        IDX_LAST   = 4'(N_REGS - 1);
  localparam logic [RAM_AW-1:0] RAM_BASE_W = RAM_AW'(RAM_BASE);

`ifdef RTC_BCD_CHECK_EN
  function automatic logic bcd_valid(input logic [7:0] b);
    bcd_valid = (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction
`endif

  state_t            state_r;
  state_t            state_nx;
  logic [5:0]        cnt_r;
  logic [5:0]        cnt_nx;
  logic [3:0]        idx_r;
  logic [3:0]        idx_nx;
  logic              phase_end_s;

  logic              busy_nx;
  logic              done_nx;
  logic              a_d_nx;
  logic              cs_n_nx;
  logic              rd_n_nx;
  logic              wr_n_nx;
  logic              ad_oe_nx;
  logic [7:0]        ad_out_nx;
  logic              ram_we_nx;
  logic [RAM_AW-1:0] ram_addr_nx;
  logic [7:0]        ram_wdata_nx;
  logic              err_nx;

  assign phase_end_s = (cnt_r == PH_LAST);

  // State, phase counter and register index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 6'd0;
      idx_r   <= 4'd0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      idx_r   <= idx_nx;
    end
  end

  // Next-state logic; the phase counter restarts on every state change
  always_comb begin
    state_nx = state_r;
    idx_nx   = idx_r;
    case (state_r)
      IDLE: begin
        idx_nx = 4'd0;
        if (start) begin
          state_nx = ADDR;
        end else begin
          state_nx = IDLE;
        end
      end
      ADDR: begin
        if (phase_end_s) begin
          state_nx = GAP;
        end else begin
          state_nx = ADDR;
        end
      end
      GAP: begin
        if (phase_end_s) begin
          state_nx = READ;
        end else begin
          state_nx = GAP;
        end
      end
      READ: begin
        if (phase_end_s) begin
          state_nx = WRITE;
        end else begin
          state_nx = READ;
        end
      end
      WRITE: begin
        state_nx = RECOV;
      end
      RECOV: begin
        if (!phase_end_s) begin
          state_nx = RECOV;
        end else if (idx_r < IDX_LAST) begin
          state_nx = ADDR;
          idx_nx   = idx_r + 4'd1;
        end else begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
        idx_nx   = 4'd0;
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = 4'd0;
      end
    endcase
    if (state_nx != state_r) begin
      cnt_nx = 6'd0;
    end else begin
      cnt_nx = cnt_r + 6'd1;
    end
  end

  // Output decode from the upcoming state, so registered outputs line up with it
  always_comb begin
    busy_nx      = (state_nx != IDLE);
    done_nx      = (state_nx == DONE);
    a_d_nx       = 1'b1;
    cs_n_nx      = 1'b1;
    rd_n_nx      = 1'b1;
    wr_n_nx      = 1'b1;
    ad_oe_nx     = 1'b0;
    ad_out_nx    = ad_out;
    ram_we_nx    = 1'b0;
    ram_addr_nx  = ram_addr;
    ram_wdata_nx = ram_wdata;
`ifdef RTC_BCD_CHECK_EN
    err_nx       = err;
`else
    err_nx       = 1'b0;
`endif
    case (state_nx)
      ADDR: begin
        cs_n_nx   = 1'b0;
        wr_n_nx   = 1'b0;
        a_d_nx    = 1'b0;
        ad_oe_nx  = 1'b1;
        ad_out_nx = RTC_BASE + {4'd0, idx_nx};
      end
      READ: begin
        cs_n_nx = 1'b0;
        rd_n_nx = 1'b0;
      end
      WRITE: begin
        // Entered only from the last READ cycle, so ad_in here is the captured byte
        ram_we_nx   = 1'b1;
        ram_addr_nx = RAM_BASE_W + RAM_AW'(idx_nx);
`ifdef RTC_BCD_CHECK_EN
        if (bcd_valid(ad_in)) begin
          ram_wdata_nx = ad_in;
        end else begin
          ram_wdata_nx = 8'h00;
          err_nx       = 1'b1;
        end
`else
        ram_wdata_nx = ad_in;
`endif
      end
      IDLE, GAP, RECOV, DONE: begin
        a_d_nx = 1'b1;
      end
      default: begin
        a_d_nx = 1'b1;
      end
    endcase
  end

  // Output registers keep the RTC strobes glitch-free
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      a_d       <= 1'b1;
      cs_n      <= 1'b1;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      ad_oe     <= 1'b0;
      ad_out    <= 8'h00;
      ram_we    <= 1'b0;
      ram_addr  <= {RAM_AW{1'b0}};
      ram_wdata <= 8'h00;
      err       <= 1'b0;
    end else begin
      busy      <= busy_nx;
      done      <= done_nx;
      a_d       <= a_d_nx;
      cs_n      <= cs_n_nx;
      rd_n      <= rd_n_nx;
      wr_n      <= wr_n_nx;
      ad_oe     <= ad_oe_nx;
      ad_out    <= ad_out_nx;
      ram_we    <= ram_we_nx;
      ram_addr  <= ram_addr_nx;
      ram_wdata <= ram_wdata_nx;
      err       <= err_nx;
    end
  end

endmodule

// File: tb/tb_rtc_burst_reader.sv
// Directed self-checking bench for rtc_burst_reader (N_REGS=3, PHASE_CYC=4),
// with a second instance at RAM_BASE=15 for address wrap.
module tb_rtc_burst_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       start_w = 1'b0;

  logic       busy, done, a_d, cs_n, rd_n, wr_n, ad_oe, ram_we, err;
  logic [7:0] ad_out, ad_in, ram_wdata;
  logic [3:0] ram_addr;

  logic       busy_w, done_w, a_d_w, cs_n_w, rd_n_w, wr_n_w, ad_oe_w, ram_we_w, err_w;
  logic [7:0] ad_out_w, ad_in_w, ram_wdata_w;
  logic [3:0] ram_addr_w;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rtc_burst_reader #(.N_REGS(3), .PHASE_CYC(4), .RTC_BASE(8'h24), .RAM_BASE(0), .RAM_AW(4)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .a_d(a_d),
    .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .ad_oe(ad_oe), .ad_out(ad_out), .ad_in(ad_in),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .err(err)
  );

  rtc_burst_reader #(.N_REGS(3), .PHASE_CYC(4), .RTC_BASE(8'h24), .RAM_BASE(15), .RAM_AW(4)) dut_w (
    .clk(clk), .reset(reset), .start(start_w), .busy(busy_w), .done(done_w), .a_d(a_d_w),
    .cs_n(cs_n_w), .rd_n(rd_n_w), .wr_n(wr_n_w), .ad_oe(ad_oe_w), .ad_out(ad_out_w), .ad_in(ad_in_w),
    .ram_we(ram_we_w), .ram_addr(ram_addr_w), .ram_wdata(ram_wdata_w), .err(err_w)
  );

  // RTC model: latch address during the address phase, return table data by address
  logic [7:0] rtc_data [0:2];
  logic [7:0] lat = 8'h00;
  logic [7:0] lat_w = 8'h00;
  logic [7:0] off, off_w;

  always @(posedge clk) begin
    if (!a_d) lat <= ad_out;
    if (!a_d_w) lat_w <= ad_out_w;
  end

  always_comb begin
    off   = lat - 8'h24;
    off_w = lat_w - 8'h24;
    ad_in   = (off < 8'd3) ? rtc_data[off[1:0]] : 8'hFF;
    ad_in_w = (off_w < 8'd3) ? rtc_data[off_w[1:0]] : 8'hFF;
  end

  // Monitor: log RAM writes, address-phase addresses and done pulses
  logic [3:0] wa_q[$];
  logic [7:0] wd_q[$];
  logic [7:0] ao_q[$];
  logic [3:0] wa_w_q[$];
  int done_cnt = 0;
  logic a_d_prev = 1'b1;

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      wa_q.push_back(ram_addr);
      wd_q.push_back(ram_wdata);
    end
    if (ram_we_w === 1'b1) wa_w_q.push_back(ram_addr_w);
    if (done === 1'b1) done_cnt++;
    if (a_d === 1'b0 && a_d_prev === 1'b1) ao_q.push_back(ad_out);
    a_d_prev = a_d;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rtc(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    rtc_data[0] = a;
    rtc_data[1] = b;
    rtc_data[2] = c;
  endtask

  task automatic run_burst(output logic ok);
    int cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    ok = (done === 1'b1);
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    start_w = 1'b0;
    set_rtc(8'h15, 8'h09, 8'h23);
    tick();
    tick();
    checks++;
    if ({cs_n, rd_n, wr_n, a_d, ad_oe} !== 5'b11110) begin
      failures++; $display("FAIL reset_strobes: got %b expected 11110", {cs_n, rd_n, wr_n, a_d, ad_oe});
    end
    checks++;
    if ({busy, done, ram_we} !== 3'b000) begin
      failures++; $display("FAIL reset_flags: got %b expected 000", {busy, done, ram_we});
    end
    checks++;
    if ({ad_out, ram_addr, ram_wdata} !== 20'h00000) begin
      failures++; $display("FAIL reset_buses: got %h expected 00000", {ad_out, ram_addr, ram_wdata});
    end
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL reset_err: got %b expected 0", err);
    end
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy, cs_n, ram_we} !== 3'b010) begin
      failures++; $display("FAIL idle_after_reset: got %b expected 010", {busy, cs_n, ram_we});
    end
  endtask

  task automatic test_basic_burst();
    int cyc;
    int n0, a0;
    logic [7:0] exp_d [3];
    logic [7:0] exp_a [3];
    exp_d = '{8'h15, 8'h09, 8'h23};
    exp_a = '{8'h24, 8'h25, 8'h26};
    set_rtc(8'h15, 8'h09, 8'h23);
    n0 = wa_q.size();
    a0 = ao_q.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 120) begin
      if (cyc == 1) begin
        checks++;
        if ({cs_n, rd_n, wr_n, a_d, ad_oe, busy} !== 6'b010011 || ad_out !== 8'h24) begin
          failures++; $display("FAIL addr_phase: got %b/%h expected 010011/24", {cs_n, rd_n, wr_n, a_d, ad_oe, busy}, ad_out);
        end
      end
      if (cyc == 4 || cyc == 5) begin
        checks++;
        if ({cs_n, rd_n, wr_n, a_d, ad_oe} !== ((cyc == 4) ? 5'b01001 : 5'b11110)) begin
          failures++; $display("FAIL addr_gap_edge c%0d: got %b", cyc, {cs_n, rd_n, wr_n, a_d, ad_oe});
        end
      end
      if (cyc == 9) begin
        checks++;
        if ({cs_n, rd_n, wr_n, a_d, ad_oe} !== 5'b00110) begin
          failures++; $display("FAIL read_phase: got %b expected 00110", {cs_n, rd_n, wr_n, a_d, ad_oe});
        end
      end
      if (cyc == 12 || cyc == 14) begin
        checks++;
        if (ram_we !== 1'b0) begin
          failures++; $display("FAIL we_outside_write c%0d: got %b expected 0", cyc, ram_we);
        end
      end
      if (cyc == 13) begin
        checks++;
        if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 4'h0, 8'h15} || {cs_n, rd_n, wr_n} !== 3'b111) begin
          failures++; $display("FAIL write_cycle: got %b %h %h expected 1 0 15", ram_we, ram_addr, ram_wdata);
        end
      end
      tick();
      cyc++;
    end
    checks++;
    if (cyc != 52 || done !== 1'b1) begin
      failures++; $display("FAIL done_latency: got %0d expected 52", cyc);
    end
    checks++;
    if ({busy, cs_n, rd_n, wr_n, ad_oe} !== 5'b11110) begin
      failures++; $display("FAIL done_state: got %b expected 11110", {busy, cs_n, rd_n, wr_n, ad_oe});
    end
    tick();
    checks++;
    if ({done, busy} !== 2'b00) begin
      failures++; $display("FAIL done_pulse_width: got %b expected 00", {done, busy});
    end
    checks++;
    if (wa_q.size() - n0 != 3 || ao_q.size() - a0 != 3) begin
      failures++; $display("FAIL basic_counts: got writes %0d addrs %0d expected 3 3", wa_q.size() - n0, ao_q.size() - a0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wa_q[n0 + i] !== 4'(i) || wd_q[n0 + i] !== exp_d[i] || ao_q[a0 + i] !== exp_a[i]) begin
          failures++; $display("FAIL basic_reg%0d: got %h:%h addr %h expected %h:%h addr %h",
                               i, wa_q[n0 + i], wd_q[n0 + i], ao_q[a0 + i], 4'(i), exp_d[i], exp_a[i]);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    int n0, d0;
    set_rtc(8'h15, 8'h09, 8'h23);
    n0 = wa_q.size();
    d0 = done_cnt;
    start = 1'b1;
    tick();
    for (int cyc = 1; cyc < 70; cyc++) begin
      start = ((cyc % 3 == 0) && cyc <= 51) || (cyc == 52);
      tick();
    end
    start = 1'b0;
    tick();
    checks++;
    if (wa_q.size() - n0 != 3) begin
      failures++; $display("FAIL start_ignored_writes: got %0d expected 3", wa_q.size() - n0);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++; $display("FAIL start_ignored_done: got %0d expected 1", done_cnt - d0);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL start_ignored_idle: got busy %b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int n0, d0, bad;
    set_rtc(8'h15, 8'h09, 8'h23);
    n0 = wa_q.size();
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc < 27; cyc++) tick();
    checks++;
    if ({cs_n, rd_n} !== 2'b00) begin
      failures++; $display("FAIL mid_in_read: got %b expected 00", {cs_n, rd_n});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({cs_n, rd_n, wr_n, a_d, ad_oe, ram_we, busy} !== 7'b1111000) begin
      failures++; $display("FAIL mid_reset_release: got %b expected 1111000", {cs_n, rd_n, wr_n, a_d, ad_oe, ram_we, busy});
    end
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 60; i++) tick();
    bad = 0;
    for (int i = n0; i < wa_q.size(); i++) begin
      if (wa_q[i] === 4'h1) bad++;
    end
    checks++;
    if (wa_q.size() - n0 != 1 || bad != 0) begin
      failures++; $display("FAIL mid_no_write: got writes %0d to_addr1 %0d expected 1 0", wa_q.size() - n0, bad);
    end
    checks++;
    if (done_cnt - d0 != 0) begin
      failures++; $display("FAIL mid_no_done: got %0d expected 0", done_cnt - d0);
    end
  endtask

  task automatic test_bcd();
    int n0;
    logic ok;
    set_rtc(8'h15, 8'h3A, 8'h23);
    n0 = wa_q.size();
    run_burst(ok);
    checks++;
    if (!ok || wa_q.size() - n0 != 3) begin
      failures++; $display("FAIL bcd_burst: got done %b writes %0d expected 1 3", ok, wa_q.size() - n0);
    end else begin
      checks++;
`ifdef RTC_BCD_CHECK_EN
      if (wd_q[n0 + 1] !== 8'h00 || err !== 1'b1 || wd_q[n0 + 2] !== 8'h23) begin
        failures++; $display("FAIL bcd_flag: got %h %h err %b expected 00 23 err 1", wd_q[n0 + 1], wd_q[n0 + 2], err);
      end
`else
      if (wd_q[n0 + 1] !== 8'h3A || err !== 1'b0) begin
        failures++; $display("FAIL bcd_passthru: got %h err %b expected 3a err 0", wd_q[n0 + 1], err);
      end
`endif
    end
    set_rtc(8'h15, 8'h09, 8'h23);
    n0 = wa_q.size();
    run_burst(ok);
    checks++;
    if (!ok || wa_q.size() - n0 != 3) begin
      failures++; $display("FAIL clean_burst: got done %b writes %0d expected 1 3", ok, wa_q.size() - n0);
    end else begin
      checks++;
`ifdef RTC_BCD_CHECK_EN
      if (wd_q[n0 + 1] !== 8'h09 || err !== 1'b1) begin
        failures++; $display("FAIL err_sticky: got %h err %b expected 09 err 1", wd_q[n0 + 1], err);
      end
`else
      if (wd_q[n0 + 1] !== 8'h09 || err !== 1'b0) begin
        failures++; $display("FAIL err_tied: got %h err %b expected 09 err 0", wd_q[n0 + 1], err);
      end
`endif
    end
  endtask

  task automatic test_ram_wrap();
    int cyc, n0;
    set_rtc(8'h15, 8'h09, 8'h23);
    n0 = wa_w_q.size();
    start_w = 1'b1;
    tick();
    start_w = 1'b0;
    cyc = 1;
    while (done_w !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc != 52) begin
      failures++; $display("FAIL wrap_latency: got %0d expected 52", cyc);
    end
    tick();
    checks++;
    if (wa_w_q.size() - n0 != 3) begin
      failures++; $display("FAIL wrap_count: got %0d expected 3", wa_w_q.size() - n0);
    end else begin
      checks++;
      if ({wa_w_q[n0], wa_w_q[n0 + 1], wa_w_q[n0 + 2]} !== 12'hF01) begin
        failures++; $display("FAIL wrap_addrs: got %h %h %h expected f 0 1", wa_w_q[n0], wa_w_q[n0 + 1], wa_w_q[n0 + 2]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_start_ignored();
    test_reset_mid();
    test_bcd();
    test_ram_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
